// File: rtl/pipeline_stage_elastic_pkg.sv
// Shared pipeline definitions: stage occupancy encoding and the packed payload
// layouts of the DE, EM and MW stage registers.
package pipeline_stage_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // Decode -> execute payload
  localparam int DE_PC_W      = 32;
  localparam int DE_INSTR_W   = 32;
  localparam int DE_PC_OFF    = 0;
  localparam int DE_INSTR_OFF = DE_PC_OFF + DE_PC_W;
  localparam int DE_W         = DE_INSTR_OFF + DE_INSTR_W;

  // Execute -> memory payload
  localparam int EM_ALU_W     = 32;
  localparam int EM_STORE_W   = 32;
  localparam int EM_RD_W      = 5;
  localparam int EM_CTRL_W    = 4;
  localparam int EM_ALU_OFF   = 0;
  localparam int EM_STORE_OFF = EM_ALU_OFF + EM_ALU_W;
  localparam int EM_RD_OFF    = EM_STORE_OFF + EM_STORE_W;
  localparam int EM_CTRL_OFF  = EM_RD_OFF + EM_RD_W;
  localparam int EM_W         = EM_CTRL_OFF + EM_CTRL_W;

  // Memory -> writeback payload
  localparam int MW_RESULT_W   = 32;
  localparam int MW_RD_W       = 5;
  localparam int MW_WB_EN_W    = 1;
  localparam int MW_RESULT_OFF = 0;
  localparam int MW_RD_OFF     = MW_RESULT_OFF + MW_RESULT_W;
  localparam int MW_WB_EN_OFF  = MW_RD_OFF + MW_RD_W;
  localparam int MW_W          = MW_WB_EN_OFF + MW_WB_EN_W;

  function automatic logic [1:0] occ_of(input occ_state_e st);
    logic [1:0] n;
    case (st)
      ST_EMPTY: n = 2'd0;
      ST_HALF:  n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipeline_stage_elastic_entry_reg.sv
// One held pipeline entry: a valid bit plus payload, with load, drop and
// flush-clear controls (clear wins over load, load wins over drop).
module pipeline_entry_reg #(
  parameter int DATA_W   = 32,
  parameter int CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // valid bit and payload storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      if (CLR_DATA != 0) data_r <= {DATA_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= d;
    end else if (drop) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline stage: main register drives the outputs, an optional skid
// entry absorbs one push during a stall so in_ready can be registered.
module pipeline_stage_elastic
  import pipeline_stage_elastic_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_state_e        state_r, state_nxt_s;
  logic              push_s, pop_s, in_ready_s;
  logic              main_valid_s, skid_valid_s;
  logic [DATA_W-1:0] main_data_s, skid_data_s, main_d_s;
  logic              main_load_s, main_drop_s, skid_load_s, skid_drop_s;

  assign push_s = in_valid & in_ready_s;
  assign pop_s  = main_valid_s & out_ready;

  // steering between input, skid and main entries
  always_comb begin
    main_load_s = 1'b0;
    main_drop_s = 1'b0;
    skid_load_s = 1'b0;
    skid_drop_s = 1'b0;
    main_d_s    = in_data;
    if (pop_s && skid_valid_s) begin
      main_load_s = 1'b1;
      main_d_s    = skid_data_s;
      skid_drop_s = 1'b1;
      skid_load_s = push_s;
    end else if (push_s && (!main_valid_s || pop_s)) begin
      main_load_s = 1'b1;
    end else if (push_s) begin
      skid_load_s = 1'b1;
    end else if (pop_s) begin
      main_drop_s = 1'b1;
    end else begin
      main_drop_s = 1'b0;
    end
  end

  // occupancy next-state; flush overrides any same-edge push or pop
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) state_nxt_s = ST_HALF;
          else        state_nxt_s = ST_EMPTY;
        end
        ST_HALF: begin
          if (push_s && !pop_s)      state_nxt_s = (SKID != 0) ? ST_FULL : ST_HALF;
          else if (pop_s && !push_s) state_nxt_s = ST_EMPTY;
          else                       state_nxt_s = ST_HALF;
        end
        ST_FULL: begin
          if (pop_s) state_nxt_s = ST_HALF;
          else       state_nxt_s = ST_FULL;
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_EMPTY;
    else     state_r <= state_nxt_s;
  end

  pipeline_entry_reg #(.DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (main_load_s),
    .drop  (main_drop_s),
    .d     (main_d_s),
    .valid (main_valid_s),
    .data  (main_data_s)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_r;

      pipeline_entry_reg #(.DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (skid_load_s),
        .drop  (skid_drop_s),
        .d     (in_data),
        .valid (skid_valid_s),
        .data  (skid_data_s)
      );

      // ready is low exactly when the skid entry will be occupied
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_r <= 1'b1;
        else     in_ready_r <= (state_nxt_s != ST_FULL);
      end

      assign in_ready_s = in_ready_r;
    end else begin : g_noskid
      assign skid_valid_s = 1'b0;
      assign skid_data_s  = {DATA_W{1'b0}};
      assign in_ready_s   = ~main_valid_s | out_ready;
    end
  endgenerate

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_s;
  assign out_data  = main_data_s;
  assign occupancy = occ_of(state_r);

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Drives three stage variants (96-bit skid/clear, 32-bit skid/retain, 32-bit
// no-skid) from one stimulus stream and scores each against a queue model.
`timescale 1ns/1ps
module tb_pipeline_stage_elastic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [95:0] in_data = 96'd0;

  always #5 clk = ~clk;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [95:0] od0;
  logic [31:0] od1, od2;
  logic [1:0]  occ0, occ1, occ2;

  pipeline_stage_elastic #(.DATA_W(96), .SKID(1), .CLR_DATA(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ0));

  pipeline_stage_elastic #(.DATA_W(32), .SKID(1), .CLR_DATA(0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data[31:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1));

  pipeline_stage_elastic #(.DATA_W(32), .SKID(0), .CLR_DATA(1)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data[31:0]), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .occupancy(occ2));

  logic        act_rdy [3];
  logic        act_ov  [3];
  logic [95:0] act_od  [3];
  logic [1:0]  act_occ [3];

  always_comb begin
    act_rdy[0] = rdy0; act_ov[0] = ov0; act_od[0] = od0;            act_occ[0] = occ0;
    act_rdy[1] = rdy1; act_ov[1] = ov1; act_od[1] = {64'd0, od1};   act_occ[1] = occ1;
    act_rdy[2] = rdy2; act_ov[2] = ov2; act_od[2] = {64'd0, od2};   act_occ[2] = occ2;
  end

  // Reference model: an in-order queue per variant plus the last value shown
  // on out_data while nothing is held.
  logic [95:0] mq   [3][$];
  logic [95:0] hold [3];
  logic [95:0] mask [3];
  bit          clr  [3];
  int          n_vec = 0;
  int          n_err = 0;

  initial begin
    mask[0] = {96{1'b1}}; mask[1] = {64'd0, {32{1'b1}}}; mask[2] = {64'd0, {32{1'b1}}};
    clr[0]  = 1'b1;       clr[1]  = 1'b0;                clr[2]  = 1'b1;
  end

  function automatic bit exp_rdy(input int k);
    if (k < 2) return mq[k].size() < 2;
    return (mq[k].size() == 0) || out_ready;
  endfunction

  task automatic chk(input int k, input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s at %0t: got %h expected %h", k, name, $time, act, exp);
    end
  endtask

  // predictor: expected entries enter the queue on accepted pushes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        hold[k] <= 96'd0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (mq[k].size() > 0) hold[k] <= mq[k][0];
        if (flush) begin
          if (clr[k]) hold[k] <= 96'd0;
          mq[k].delete();
        end else begin
          if (in_valid && exp_rdy(k)) begin
            if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
            mq[k].push_back(in_data & mask[k]);
          end else if (mq[k].size() > 0 && out_ready) begin
            void'(mq[k].pop_front());
          end
        end
      end
    end
  end

  // monitor: compare every variant each cycle, score popped entries in order
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk(k, "occupancy", {94'd0, act_occ[k]}, 96'(mq[k].size()));
      chk(k, "out_valid", {95'd0, act_ov[k]}, {95'd0, mq[k].size() > 0});
      chk(k, "in_ready",  {95'd0, act_rdy[k]}, {95'd0, exp_rdy(k)});
      chk(k, "out_data",  act_od[k], (mq[k].size() > 0) ? mq[k][0] : hold[k]);
      if (act_ov[k] && out_ready) begin
        if (mq[k].size() > 0) begin
          chk(k, "pop_data", act_od[k], mq[k][0]);
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL dut%0d pop_underflow at %0t: got pop of %h expected no entry",
                   k, $time, act_od[k]);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [95:0] d, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) drive(1'b1, 96'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, 96'd0, 1'b1, 1'b0);

    // stall into the skid entry, then release
    drive(1'b1, 96'hA, 1'b0, 1'b0);
    drive(1'b1, 96'hB, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 96'd0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 96'd0, 1'b1, 1'b0);

    // flush colliding with push and pop while full
    drive(1'b1, 96'hA, 1'b0, 1'b0);
    drive(1'b1, 96'hB, 1'b0, 1'b0);
    drive(1'b1, 96'hC, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 96'd0, 1'b1, 1'b0);

    // out_ready toggling under continuous in_valid
    for (int i = 0; i < 8; i++) drive(1'b1, 96'(16 + i), (i % 2) == 0, 1'b0);
    repeat (3) drive(1'b0, 96'd0, 1'b1, 1'b0);

    // asynchronous reset while full, observed before any clock edge
    drive(1'b1, 96'h5A, 1'b0, 1'b0);
    drive(1'b1, 96'h5B, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk(0, "rst_out_valid", {95'd0, ov0},  96'd0);
    chk(0, "rst_occupancy", {94'd0, occ0}, 96'd0);
    chk(0, "rst_out_data",  od0,           96'd0);
    chk(0, "rst_in_ready",  {95'd0, rdy0}, 96'd1);
    chk(1, "rst_out_data",  {64'd0, od1},  96'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 96'h77, 1'b1, 1'b0);
    drive(1'b0, 96'd0, 1'b1, 1'b0);

    // random traffic: 30% valid, 70% ready, 5% flush
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 100) < 30, {$urandom, $urandom, $urandom},
            ($urandom % 100) < 70, ($urandom % 100) < 5);
    end
    repeat (4) drive(1'b0, 96'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
